// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32 pipeline: data-memory request/ready handshake,
// store lane formatting, load extraction/extension and the MEM/WB register.
module mem_stage #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_alu_res,
    input  logic [31:0] EX_MEM_mem_din,
    input  logic        EX_MEM_rd_mem,
    input  logic        EX_MEM_wr_mem,
    input  logic [2:0]  EX_MEM_mem_size,
    input  logic        EX_MEM_vld,
    input  logic [31:0] mem2proc_data,
    input  logic        mem2proc_rdy,
    output logic [1:0]  proc2mem_cmd,
    output logic [31:0] proc2mem_addr,
    output logic [31:0] proc2mem_data,
    output logic [3:0]  proc2mem_be,
    output logic [31:0] MEM_data,
    output logic        MEM_busy,
    output logic        MEM_addr_err,
    output logic [31:0] MEM_WB_data,
    output logic        MEM_WB_vld,
    output logic        MEM_WB_bus_err
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_vld_q, wb_vld_d;
    logic        wb_err_q, wb_err_d;

    logic        is_load, is_store, mem_op, size_ok, misalign, acc;
    logic [1:0]  off;
    logic [3:0]  be_fmt;
    logic [31:0] st_fmt, lane, ld_fmt;
    logic        req, busy, abort;

    // Both rd and wr high is treated as a load.
    assign is_load  = EX_MEM_rd_mem;
    assign is_store = EX_MEM_wr_mem & ~EX_MEM_rd_mem;
    assign mem_op   = EX_MEM_vld & (EX_MEM_rd_mem | EX_MEM_wr_mem);
    assign off      = EX_MEM_alu_res[1:0];

    always_comb begin
        case (EX_MEM_mem_size)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = is_load;
            default:                size_ok = 1'b0;
        endcase
    end

    assign misalign     = ((EX_MEM_mem_size[1:0] == 2'b01) & off[0]) |
                          ((EX_MEM_mem_size[1:0] == 2'b10) & (off != 2'b00));
    assign MEM_addr_err = mem_op & (~size_ok | misalign);
    assign acc          = mem_op & ~MEM_addr_err;

    always_comb begin
        case (EX_MEM_mem_size[1:0])
            2'b00: begin
                be_fmt = 4'b0001 << off;
                st_fmt = {4{EX_MEM_mem_din[7:0]}};
            end
            2'b01: begin
                be_fmt = 4'b0011 << off;
                st_fmt = {2{EX_MEM_mem_din[15:0]}};
            end
            default: begin
                be_fmt = 4'b1111;
                st_fmt = EX_MEM_mem_din;
            end
        endcase
    end

    assign lane = mem2proc_data >> {off, 3'b000};

    always_comb begin
        case (EX_MEM_mem_size)
            3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_fmt = {24'h0, lane[7:0]};
            3'b101:  ld_fmt = {16'h0, lane[15:0]};
            default: ld_fmt = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        busy    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    req = 1'b1;
                    if (!mem2proc_rdy) begin
                        busy    = 1'b1;
                        state_d = WAIT;
                        cnt_d   = 8'd0;
                    end
                end
            end
            WAIT: begin
                if (!acc) begin
                    state_d = IDLE;
                end else if (mem2proc_rdy) begin
                    req     = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    req   = 1'b1;
                    busy  = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset kills any in-flight request in the same cycle.
    assign proc2mem_cmd  = (req & ~rst) ? (is_load ? 2'b01 : 2'b10) : 2'b00;
    assign MEM_busy      = busy & ~rst;
    assign proc2mem_addr = {EX_MEM_alu_res[31:2], 2'b00};
    assign proc2mem_data = st_fmt;
    assign proc2mem_be   = (req & ~rst & is_store) ? be_fmt : 4'b0000;
    assign MEM_data      = EX_MEM_alu_res;

    always_comb begin
        wb_data_d = wb_data_q;
        wb_vld_d  = 1'b0;
        wb_err_d  = 1'b0;
        if (!busy) begin
            wb_vld_d  = EX_MEM_vld & ~MEM_addr_err & ~abort;
            wb_err_d  = abort;
            wb_data_d = (acc & is_load & ~abort) ? ld_fmt : EX_MEM_alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            wb_data_q <= 32'd0;
            wb_vld_q  <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_vld_q  <= wb_vld_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign MEM_WB_data    = wb_data_q;
    assign MEM_WB_vld     = wb_vld_q;
    assign MEM_WB_bus_err = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: combinational request checks each cycle and a
// queue of expected MEM/WB contents popped one cycle after each drive.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res, mem_din, mem2proc_data;
    logic        rd_mem, wr_mem, vld, mem2proc_rdy;
    logic [2:0]  mem_size;
    logic [1:0]  cmd;
    logic [31:0] p_addr, p_data, fwd, wb_data;
    logic [3:0]  be;
    logic        busy, addr_err, wb_vld, wb_err;

    typedef struct {
        logic        vld;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } wb_t;

    wb_t q[$];
    int  tests = 0;
    int  fails = 0;

    mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_alu_res(alu_res), .EX_MEM_mem_din(mem_din),
        .EX_MEM_rd_mem(rd_mem), .EX_MEM_wr_mem(wr_mem),
        .EX_MEM_mem_size(mem_size), .EX_MEM_vld(vld),
        .mem2proc_data(mem2proc_data), .mem2proc_rdy(mem2proc_rdy),
        .proc2mem_cmd(cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
        .proc2mem_be(be), .MEM_data(fwd), .MEM_busy(busy),
        .MEM_addr_err(addr_err), .MEM_WB_data(wb_data),
        .MEM_WB_vld(wb_vld), .MEM_WB_bus_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic e, input logic cd, input logic [31:0] d);
        wb_t w;
        w.vld = v; w.err = e; w.chk_data = cd; w.data = d;
        q.push_back(w);
    endtask

    // Advance one cycle, then compare the MEM/WB register against the oldest expectation.
    task automatic tick(input string tag);
        wb_t w;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            w = q.pop_front();
            chk({tag, "_wb_vld"}, {31'd0, wb_vld}, {31'd0, w.vld});
            chk({tag, "_wb_err"}, {31'd0, wb_err}, {31'd0, w.err});
            if (w.chk_data) chk({tag, "_wb_data"}, wb_data, w.data);
        end
    endtask

    task automatic op(input logic v, input logic r, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
        vld = v; rd_mem = r; wr_mem = w; mem_size = sz; alu_res = a; mem_din = d;
    endtask

    task automatic idle_cycle();
        op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem2proc_rdy = 1'b0;
        #1;
        chk("idle_cmd", {30'd0, cmd}, 32'd0);
        chk("idle_be", {28'd0, be}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 32'h0);
        tick("idle");
    endtask

    // Load whose ready arrives after nwait busy cycles.
    task automatic wait_load(input string tag, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] rdat, input int nwait, input logic [31:0] exp);
        op(1'b1, 1'b1, 1'b0, sz, a, 32'h0);
        mem2proc_data = rdat;
        for (int i = 0; i < nwait; i++) begin
            mem2proc_rdy = 1'b0;
            #1;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_cmd"}, {30'd0, cmd}, 32'd1);
            push(1'b0, 1'b0, 1'b0, 32'h0);
            tick(tag);
        end
        mem2proc_rdy = 1'b1;
        #1;
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_cmd"}, {30'd0, cmd}, 32'd1);
        push(1'b1, 1'b0, 1'b1, exp);
        tick(tag);
    endtask

    initial begin
        rst = 1'b1;
        op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem2proc_data = 32'h0;
        mem2proc_rdy  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cmd", {30'd0, cmd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'h0);
        tick("rst");
        rst = 1'b0;

        // Zero-wait LW
        op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        mem2proc_data = 32'hDEADBEEF;
        mem2proc_rdy  = 1'b1;
        #1;
        chk("lw_cmd", {30'd0, cmd}, 32'd1);
        chk("lw_addr", p_addr, 32'h100);
        chk("lw_busy", {31'd0, busy}, 32'd0);
        chk("lw_be", {28'd0, be}, 32'd0);
        chk("lw_fwd", fwd, 32'h100);
        push(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        tick("lw");
        idle_cycle();

        wait_load("lb", 3'b000, 32'h203, 32'h80FF_0000, 3, 32'hFFFFFF80);
        wait_load("lbu", 3'b100, 32'h203, 32'h80FF_0000, 3, 32'h00000080);
        wait_load("lh", 3'b001, 32'h202, 32'h80FF_1234, 1, 32'hFFFF80FF);
        wait_load("lhu", 3'b101, 32'h200, 32'h80FF_9234, 0, 32'h00009234);
        idle_cycle();

        // Stores
        op(1'b1, 1'b0, 1'b1, 3'b001, 32'h12, 32'h0000ABCD);
        mem2proc_rdy = 1'b1;
        #1;
        chk("sh_cmd", {30'd0, cmd}, 32'd2);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_data", p_data, 32'hABCDABCD);
        chk("sh_addr", p_addr, 32'h10);
        push(1'b1, 1'b0, 1'b1, 32'h12);
        tick("sh");
        op(1'b1, 1'b0, 1'b1, 3'b000, 32'h11, 32'h0000ABCD);
        #1;
        chk("sb_be", {28'd0, be}, 32'h2);
        chk("sb_data", p_data, 32'hCDCDCDCD);
        push(1'b1, 1'b0, 1'b1, 32'h11);
        tick("sb");

        // ALU pass-through
        op(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
        mem2proc_rdy = 1'b0;
        #1;
        chk("alu_cmd", {30'd0, cmd}, 32'd0);
        chk("alu_busy", {31'd0, busy}, 32'd0);
        push(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        tick("alu");

        // Address / size errors
        op(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        #1;
        chk("mis_err", {31'd0, addr_err}, 32'd1);
        chk("mis_cmd", {30'd0, cmd}, 32'd0);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 32'h0);
        tick("mis");
        op(1'b1, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
        #1;
        chk("f3_err", {31'd0, addr_err}, 32'd1);
        chk("f3_cmd", {30'd0, cmd}, 32'd0);
        chk("f3_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 32'h0);
        tick("f3");

        // Timeout: 4 busy cycles then abort
        op(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        mem2proc_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_busy", {31'd0, busy}, 32'd1);
            chk("to_cmd", {30'd0, cmd}, 32'd1);
            push(1'b0, 1'b0, 1'b0, 32'h0);
            tick("to");
        end
        #1;
        chk("to_abort_cmd", {30'd0, cmd}, 32'd0);
        chk("to_abort_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b1, 1'b0, 32'h0);
        tick("to_abort");
        // FSM back in IDLE: a fresh access must see the full wait sequence again
        wait_load("post_to", 3'b010, 32'h44, 32'hCAFEF00D, 2, 32'hCAFEF00D);

        // Reset during the second WAIT cycle
        op(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        mem2proc_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rw_busy", {31'd0, busy}, 32'd1);
            push(1'b0, 1'b0, 1'b0, 32'h0);
            tick("rw");
        end
        rst = 1'b1;
        #1;
        chk("rw_rst_cmd", {30'd0, cmd}, 32'd0);
        chk("rw_rst_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'h0);
        tick("rw_rst");
        rst = 1'b0;
        op(1'b0, 1'b0, 1'b0, 3'b010, 32'h80, 32'h0);
        mem2proc_rdy  = 1'b1;
        mem2proc_data = 32'h5555AAAA;
        #1;
        chk("late_cmd", {30'd0, cmd}, 32'd0);
        chk("late_busy", {31'd0, busy}, 32'd0);
        push(1'b0, 1'b0, 1'b0, 32'h0);
        tick("late");
        // After reset, a zero-wait load must complete immediately from IDLE
        op(1'b1, 1'b1, 1'b0, 3'b010, 32'h84, 32'h0);
        mem2proc_data = 32'h0BADF00D;
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        push(1'b1, 1'b0, 1'b1, 32'h0BADF00D);
        tick("post_rst");
        idle_cycle();

        chk("sb_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
